apb_mem_slave: RTL and testbench

Parametrised APB completer with word-indexed memory, byte strobes, programmable wait states, an error response and a readable write counter. It replaces the fixed 32×128 APB memory slave. It sits on the APB bus behind the requester (master) model and serves as the standard memory-mapped target for bus tests.

---
 rtl/apb_mem_pkg.sv | 14 +
 rtl/apb_mem_array.sv | 27 ++
 rtl/apb_mem_slave.sv | 132 +++++++++++++
 tb/tb_apb_mem_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory completer.
package apb_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // The write-counter register sits immediately above the last memory word.
    function automatic int unsigned cnt_addr(input int unsigned depth);
        return depth;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Single-port word array: byte-enabled synchronous write, asynchronous read.
module apb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] strb_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer: word memory, byte strobes, programmable wait states,
// error response above the counter register, and a readable write counter.
//   state | meaning
//   IDLE  | waiting for a setup cycle
//   WAIT  | access phase, PREADY low while the wait counter runs down
//   RESP  | response loaded, PREADY high until completion or abort
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PRWADDR,
    input  logic [DATA_W-1:0]   PRWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(cnt_addr(DEPTH));
    localparam logic [3:0]        WS       = 4'(WAIT_STATES);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] wr_cnt_q;
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;

    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] resp_data_d;
    logic              resp_err_d;
    logic              is_mem, is_cnt, is_err;
    logic              done, mem_we;

    always_comb begin
        is_mem      = PRWADDR < CNT_ADDR;
        is_cnt      = PRWADDR == CNT_ADDR;
        is_err      = PRWADDR > CNT_ADDR;
        resp_err_d  = is_err ? RESP_ERR : RESP_OKAY;
        resp_data_d = '0;
        if (!PWRITE) begin
            if (is_mem)      resp_data_d = mem_rdata;
            else if (is_cnt) resp_data_d = wr_cnt_q;
        end
    end

    assign done   = (state_q == RESP) && PSEL && PENABLE && pready_q;
    assign mem_we = done && PWRITE && is_mem;

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk_i   (PCLK),
        .we_i    (mem_we),
        .addr_i  (PRWADDR[AW-1:0]),
        .wdata_i (PRWDATA),
        .strb_i  (PSTRB),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_cnt_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    // PENABLE without a preceding setup cycle is ignored here.
                    if (PSEL && !PENABLE) begin
                        cnt_q <= WS;
                        if (WS == 4'd0) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= resp_err_d;
                            prdata_q  <= resp_data_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= resp_err_d;
                            prdata_q  <= resp_data_d;
                        end
                    end
                end
                RESP: begin
                    if (!PSEL || done) begin
                        if (done && PWRITE && is_cnt) begin
                            wr_cnt_q <= '0;
                        end else if (mem_we && (|PSTRB)) begin
                            wr_cnt_q <= wr_cnt_q + DATA_W'(1);
                        end
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= RESP_OKAY;
                        prdata_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: three completers (0, 2 and 3 wait states) on one clock,
// each checked against a word/byte-level reference model of the address map.
module tb_apb_mem_slave;

    localparam int DEPTH = 16;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic [2:0]        psel;
    logic              penable, pwrite;
    logic [31:0]       paddr, pwdata;
    logic [3:0]        pstrb;
    logic [2:0][31:0]  prdata;
    logic [2:0]        pready, pslverr;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ws_of [3] = '{0, 2, 3};

    logic [31:0] mem_m   [3][DEPTH];
    bit          known_m [3][DEPTH];
    logic [31:0] cnt_m   [3];

    logic [31:0] got_data, exp_data;
    logic        got_err, exp_err, rdy_after;
    bit          exp_known;
    int          lat, done_cyc;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .PCLK(pclk), .PRESET(preset_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PRWADDR(paddr), .PRWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .PCLK(pclk), .PRESET(preset_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PRWADDR(paddr), .PRWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .PCLK(pclk), .PRESET(preset_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PRWADDR(paddr), .PRWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    // Reference model: address map rules applied directly to words and bytes.
    task automatic model_xfer(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
        exp_data  = '0;
        exp_err   = 1'b0;
        exp_known = 1'b1;
        if (addr > DEPTH) begin
            exp_err = 1'b1;
        end else if (addr == DEPTH) begin
            if (wr) cnt_m[d] = '0;
            else    exp_data = cnt_m[d];
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem_m[d][int'(addr)][8*b +: 8] = data[8*b +: 8];
            if (strb == 4'hF) known_m[d][int'(addr)] = 1'b1;
            if (strb != 4'h0) cnt_m[d] = cnt_m[d] + 32'd1;
        end else begin
            exp_data  = mem_m[d][int'(addr)];
            exp_known = known_m[d][int'(addr)];
        end
    endtask

    // One APB transfer, starting in the current cycle; ends 1 time unit after completion.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 2;
        while (pready[d] !== 1'b1 && lat < 40) begin
            @(posedge pclk); #1;
            lat++;
        end
        if (pready[d] !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: dut %0d PREADY never rose within %0d cycles", d, lat);
        end
        got_data = prdata[d];
        got_err  = pslverr[d];
        @(posedge pclk); #1;
        done_cyc  = cyc;
        rdy_after = pready[d];
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic run(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
        xfer(d, wr, addr, data, strb);
        model_xfer(d, wr, addr, data, strb);
    endtask

    task automatic test_reset();
        preset_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        for (int d = 0; d < 3; d++) begin
            cnt_m[d] = '0;
            for (int a = 0; a < DEPTH; a++) known_m[d][a] = 1'b0;
        end
        repeat (2) @(posedge pclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({pready[d], pslverr[d], prdata[d]} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut %0d: got rdy=%b err=%b data=%h expected 0/0/0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
        end
        preset_n = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_basic();
        run(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        n_checks++;
        if (lat !== 2 || got_err !== 1'b0 || rdy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_write: got lat=%0d err=%b rdy_after=%b expected 2/0/0", lat, got_err, rdy_after);
        end
        run(0, 1'b0, 32'd5, 32'h0, 4'h0);
        n_checks++;
        if (lat !== 2 || got_err !== 1'b0 || got_data !== 32'hDEADBEEF || got_data !== exp_data) begin
            n_fail++;
            $display("FAIL basic_read: got lat=%0d err=%b data=%h expected 2/0/%h", lat, got_err, got_data, exp_data);
        end
        run(0, 1'b0, DEPTH, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data || got_data !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_counter: got %h expected %h", got_data, exp_data);
        end
    endtask

    task automatic test_strobes();
        run(0, 1'b1, 32'd7, 32'h11223344, 4'hF);
        run(0, 1'b1, 32'd7, 32'hAABBCCDD, 4'h5);
        run(0, 1'b0, 32'd7, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== 32'h11BB33DD || got_data !== exp_data) begin
            n_fail++;
            $display("FAIL strobe_merge: got %h expected %h", got_data, exp_data);
        end
        run(0, 1'b1, 32'd7, 32'hFFFFFFFF, 4'h0);
        n_checks++;
        if (got_err !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("FAIL strobe_zero_resp: got err=%b lat=%0d expected 0/2", got_err, lat);
        end
        run(0, 1'b0, 32'd7, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL strobe_zero_data: got %h expected %h", got_data, exp_data);
        end
        run(0, 1'b0, DEPTH, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data || got_data !== 32'd3) begin
            n_fail++;
            $display("FAIL counter_after_3: got %h expected %h", got_data, exp_data);
        end
    endtask

    task automatic test_counter();
        run(0, 1'b1, DEPTH, 32'h12345678, 4'hF);
        n_checks++;
        if (got_err !== 1'b0 || got_data !== 32'h0) begin
            n_fail++;
            $display("FAIL counter_clear_resp: got err=%b data=%h expected 0/0", got_err, got_data);
        end
        run(0, 1'b0, DEPTH, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data || got_data !== 32'd0) begin
            n_fail++;
            $display("FAIL counter_clear: got %h expected %h", got_data, exp_data);
        end
    endtask

    task automatic test_error();
        run(0, 1'b1, 32'd1, 32'h01010101, 4'hF);
        run(0, 1'b0, DEPTH + 1, 32'h0, 4'h0);
        n_checks++;
        if (got_err !== 1'b1 || got_data !== 32'h0) begin
            n_fail++;
            $display("FAIL err_read: got err=%b data=%h expected 1/0", got_err, got_data);
        end
        run(0, 1'b1, DEPTH + 1, 32'h55, 4'hF);
        n_checks++;
        if (got_err !== 1'b1 || got_err !== exp_err) begin
            n_fail++;
            $display("FAIL err_write: got err=%b expected 1", got_err);
        end
        run(0, 1'b0, 32'd1, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data || got_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_mem_intact: got %h expected %h", got_data, exp_data);
        end
        run(0, 1'b0, DEPTH, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL err_cnt_intact: got %h expected %h", got_data, exp_data);
        end
    endtask

    task automatic test_wait_states();
        int prev;
        run(2, 1'b1, 32'd0, 32'hCAFE0001, 4'hF);
        run(2, 1'b0, 32'd0, 32'h0, 4'h0);
        n_checks++;
        if (lat !== 5 || got_data !== exp_data) begin
            n_fail++;
            $display("FAIL ws3_read: got lat=%0d data=%h expected 5/%h", lat, got_data, exp_data);
        end
        prev = done_cyc;
        for (int i = 0; i < 3; i++) begin
            run(2, 1'b0, 32'd0, 32'h0, 4'h0);
            n_checks++;
            if (done_cyc - prev !== 5 || got_data !== exp_data) begin
                n_fail++;
                $display("FAIL ws3_back_to_back %0d: got period=%0d data=%h expected 5/%h",
                         i, done_cyc - prev, got_data, exp_data);
            end
            prev = done_cyc;
        end
    endtask

    task automatic test_abort();
        bit rose;
        run(1, 1'b1, 32'd4, 32'h44444444, 4'hF);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL ws2_latency: got %0d expected 4", lat);
        end
        rose = 1'b0;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd4; pwdata = 32'h99999999; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        rose |= pready[1];
        @(posedge pclk); #1;
        rose |= pready[1];
        psel[1] = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(posedge pclk); #1;
            rose |= pready[1];
        end
        n_checks++;
        if (rose !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pready: got rose=%b expected 0", rose);
        end
        run(1, 1'b0, 32'd4, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL abort_mem: got %h expected %h", got_data, exp_data);
        end
        run(1, 1'b0, DEPTH, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL abort_cnt: got %h expected %h", got_data, exp_data);
        end
    endtask

    task automatic test_reset_in_resp();
        run(0, 1'b1, 32'd6, 32'h66666666, 4'hF);
        for (int v = 0; v < 2; v++) begin
            psel[0] = 1'b1; penable = 1'b0; pwrite = (v == 1);
            paddr = (v == 1) ? 32'd6 : 32'd5; pwdata = 32'h0BAD0BAD; pstrb = 4'hF;
            @(posedge pclk); #1;
            penable = 1'b1;
            n_checks++;
            if (pready[0] !== 1'b1 || (v == 0 && prdata[0] !== mem_m[0][5])) begin
                n_fail++;
                $display("FAIL resp_before_reset %0d: got rdy=%b data=%h", v, pready[0], prdata[0]);
            end
            preset_n = 1'b0;
            #1;
            n_checks++;
            if ({pready[0], pslverr[0], prdata[0]} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_in_resp %0d: got rdy=%b err=%b data=%h expected 0/0/0",
                         v, pready[0], pslverr[0], prdata[0]);
            end
            psel[0] = 1'b0; penable = 1'b0;
            for (int d = 0; d < 3; d++) cnt_m[d] = '0;
            @(posedge pclk); #1;
            preset_n = 1'b1;
            @(posedge pclk); #1;
        end
        run(0, 1'b0, 32'd6, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data || lat !== 2) begin
            n_fail++;
            $display("FAIL after_reset_mem: got %h lat=%0d expected %h/2", got_data, lat, exp_data);
        end
        run(0, 1'b0, DEPTH, 32'h0, 4'h0);
        n_checks++;
        if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL after_reset_cnt: got %h expected %h", got_data, exp_data);
        end
    endtask

    task automatic test_random(input int d);
        logic [31:0] addr, data;
        logic [3:0]  strb;
        bit          wr;
        for (int a = 0; a < DEPTH; a++) run(d, 1'b1, a, $urandom, 4'hF);
        for (int i = 0; i < 40; i++) begin
            addr = $urandom_range(0, DEPTH + 2);
            wr   = 1'($urandom_range(0, 1));
            strb = 4'($urandom_range(0, 15));
            data = $urandom;
            run(d, wr, addr, data, strb);
            n_checks++;
            if (got_err !== exp_err || lat !== 2 + ws_of[d] || rdy_after !== 1'b0 ||
                (exp_known && got_data !== exp_data)) begin
                n_fail++;
                $display("FAIL random dut %0d op %0d wr=%b addr=%0d: got err=%b data=%h lat=%0d expected %b/%h/%0d",
                         d, i, wr, addr, got_err, got_data, lat, exp_err, exp_data, 2 + ws_of[d]);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_counter();
        test_error();
        test_wait_states();
        test_abort();
        test_reset_in_resp();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
